// File: rtl/ctrl_relogio_pkg.sv
// Shared types and default timing for the digital clock (controller and display driver).
package relogio_pkg;

    typedef enum logic [1:0] {
        MODO_RUN         = 2'd0,
        MODO_AJUSTE_HORA = 2'd1,
        MODO_AJUSTE_MIN  = 2'd2
    } modo_t;

    localparam int CLK_HZ_DEF        = 50_000_000;
    localparam int SEC_PER_MIN_DEF   = 60;
    localparam int BLINK_CYCLES_DEF  = 25_000_000;
    localparam int HOLD_CYCLES_DEF   = 50_000_000;
    localparam int REPEAT_CYCLES_DEF = 10_000_000;

endpackage

// File: rtl/ctrl_relogio_if.sv
// Button/carry inputs and minute/hour machine controls of the clock controller.
import relogio_pkg::*;

interface ctrl_relogio_if;
    logic  ctrl_btn_modo;
    logic  ctrl_btn_inc;
    logic  ctrl_carry_min;
    logic  ctrl_min_enable;
    logic  ctrl_min_incremento;
    logic  ctrl_hora_enable;
    logic  ctrl_hora_incremento;
    modo_t ctrl_modo;
    logic  ctrl_blank_min;
    logic  ctrl_blank_hora;

    modport master (
        output ctrl_btn_modo, ctrl_btn_inc, ctrl_carry_min,
        input  ctrl_min_enable, ctrl_min_incremento, ctrl_hora_enable,
               ctrl_hora_incremento, ctrl_modo, ctrl_blank_min, ctrl_blank_hora
    );

    modport slave (
        input  ctrl_btn_modo, ctrl_btn_inc, ctrl_carry_min,
        output ctrl_min_enable, ctrl_min_incremento, ctrl_hora_enable,
               ctrl_hora_incremento, ctrl_modo, ctrl_blank_min, ctrl_blank_hora
    );
endinterface

// File: rtl/ctrl_relogio_detector_borda.sv
// Registered rising-edge detector: one-cycle pulse one edge after the input is first sampled high.
module detector_borda (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sinal,
    output logic o_borda
);
    logic r_prev;
    logic r_borda;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev  <= 1'b0;
            r_borda <= 1'b0;
        end else begin
            r_prev  <= i_sinal;
            r_borda <= i_sinal & ~r_prev;
        end
    end

    assign o_borda = r_borda;
endmodule

// File: rtl/ctrl_relogio.sv
// Mode controller / minute tick scheduler for the digital clock.
// Optional feature: CTRL_AUTOREPEAT_EN enables auto-repeat of a held inc button in set modes.
import relogio_pkg::*;

module ctrl_relogio #(
    parameter int CLK_HZ        = CLK_HZ_DEF,
    parameter int SEC_PER_MIN   = SEC_PER_MIN_DEF,
    parameter int BLINK_CYCLES  = BLINK_CYCLES_DEF,
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic           ctrl_clock,
    input  logic           ctrl_reset,
    ctrl_relogio_if.slave  bus
);
    localparam logic [63:0] PRESC_N = 64'(CLK_HZ) * 64'(SEC_PER_MIN);
    localparam int PRESC_W = (PRESC_N > 64'd1) ? $clog2(PRESC_N) : 1;
    localparam logic [PRESC_W-1:0] PRESC_TOP = PRESC_W'(PRESC_N - 64'd1);
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_TOP = BLINK_W'(BLINK_CYCLES - 1);

    if (CLK_HZ < 1 || SEC_PER_MIN < 1 || BLINK_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1)
    begin : g_param_err
        $error("ctrl_relogio: timing parameters must be >= 1");
    end

    modo_t               r_modo, w_modo_nxt;
    logic [PRESC_W-1:0]  r_presc, w_presc_nxt;
    logic [BLINK_W-1:0]  r_blink, w_blink_nxt;
    logic                r_fase, w_fase_nxt;
    logic                r_run_orig, w_run_orig_nxt;
    logic                w_min_inc_nxt, w_hora_inc_nxt;
    logic                r_min_inc, r_hora_inc, r_min_en, r_hora_en, r_blank_min, r_blank_hora;
    logic                w_modo_borda, w_inc_borda, w_repete, w_inc_ok;

    detector_borda u_borda_modo (
        .i_clk(ctrl_clock), .i_rst(ctrl_reset), .i_sinal(bus.ctrl_btn_modo), .o_borda(w_modo_borda)
    );
    detector_borda u_borda_inc (
        .i_clk(ctrl_clock), .i_rst(ctrl_reset), .i_sinal(bus.ctrl_btn_inc), .o_borda(w_inc_borda)
    );

`ifdef CTRL_AUTOREPEAT_EN
    localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_TOP  = HOLD_W'(REPEAT_CYCLES - 1);

    logic              r_inc_nivel;
    logic [HOLD_W-1:0] r_hold, w_hold_nxt;
    logic              r_rep, w_rep_nxt;

    // Counts held cycles after the initial pulse; r_rep selects the repeat interval.
    always_comb begin
        w_hold_nxt = '0;
        w_rep_nxt  = 1'b0;
        w_repete   = 1'b0;
        if (!w_inc_borda && r_inc_nivel && !w_modo_borda && r_modo != MODO_RUN) begin
            if (r_hold == (r_rep ? REP_TOP : HOLD_TOP)) begin
                w_repete  = 1'b1;
                w_rep_nxt = 1'b1;
            end else begin
                w_hold_nxt = r_hold + HOLD_W'(1);
                w_rep_nxt  = r_rep;
            end
        end
    end

    always_ff @(posedge ctrl_clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_inc_nivel <= 1'b0;
            r_hold      <= '0;
            r_rep       <= 1'b0;
        end else begin
            r_inc_nivel <= bus.ctrl_btn_inc;
            r_hold      <= w_hold_nxt;
            r_rep       <= w_rep_nxt;
        end
    end
`else
    assign w_repete = 1'b0;
`endif

    // A mode edge always wins over an inc edge in the same cycle.
    assign w_inc_ok = (w_inc_borda | w_repete) & ~w_modo_borda;

    always_comb begin
        w_modo_nxt     = r_modo;
        w_presc_nxt    = r_presc;
        w_blink_nxt    = r_blink;
        w_fase_nxt     = r_fase;
        w_run_orig_nxt = r_run_orig;
        w_min_inc_nxt  = 1'b0;
        w_hora_inc_nxt = bus.ctrl_carry_min & r_run_orig;
        case (r_modo)
            MODO_RUN: begin
                if (r_presc == PRESC_TOP) begin
                    w_presc_nxt    = '0;
                    w_min_inc_nxt  = 1'b1;
                    w_run_orig_nxt = 1'b1;
                end else begin
                    w_presc_nxt = r_presc + PRESC_W'(1);
                end
                if (w_modo_borda) w_modo_nxt = MODO_AJUSTE_HORA;
            end
            MODO_AJUSTE_HORA: begin
                if (w_inc_ok) w_hora_inc_nxt = 1'b1;
                if (w_modo_borda) w_modo_nxt = MODO_AJUSTE_MIN;
            end
            MODO_AJUSTE_MIN: begin
                if (w_inc_ok) begin
                    w_min_inc_nxt  = 1'b1;
                    w_run_orig_nxt = 1'b0;
                end
                if (w_modo_borda) begin
                    w_modo_nxt  = MODO_RUN;
                    w_presc_nxt = '0;
                end
            end
            default: begin
                w_modo_nxt  = MODO_RUN;
                w_presc_nxt = '0;
            end
        endcase

        if (w_modo_nxt != r_modo) begin
            w_blink_nxt = '0;
            w_fase_nxt  = 1'b0;
        end else if (r_modo != MODO_RUN) begin
            if (r_blink == BLINK_TOP) begin
                w_blink_nxt = '0;
                w_fase_nxt  = ~r_fase;
            end else begin
                w_blink_nxt = r_blink + BLINK_W'(1);
            end
        end
    end

    always_ff @(posedge ctrl_clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_modo       <= MODO_RUN;
            r_presc      <= '0;
            r_blink      <= '0;
            r_fase       <= 1'b0;
            r_run_orig   <= 1'b0;
            r_min_inc    <= 1'b0;
            r_hora_inc   <= 1'b0;
            r_min_en     <= 1'b1;
            r_hora_en    <= 1'b1;
            r_blank_min  <= 1'b0;
            r_blank_hora <= 1'b0;
        end else begin
            r_modo       <= w_modo_nxt;
            r_presc      <= w_presc_nxt;
            r_blink      <= w_blink_nxt;
            r_fase       <= w_fase_nxt;
            r_run_orig   <= w_run_orig_nxt;
            r_min_inc    <= w_min_inc_nxt;
            r_hora_inc   <= w_hora_inc_nxt;
            r_min_en     <= (w_modo_nxt != MODO_AJUSTE_HORA);
            r_hora_en    <= (w_modo_nxt != MODO_AJUSTE_MIN);
            r_blank_min  <= (w_modo_nxt == MODO_AJUSTE_MIN) & w_fase_nxt;
            r_blank_hora <= (w_modo_nxt == MODO_AJUSTE_HORA) & w_fase_nxt;
        end
    end

    assign bus.ctrl_modo            = r_modo;
    assign bus.ctrl_min_enable      = r_min_en;
    assign bus.ctrl_hora_enable     = r_hora_en;
    assign bus.ctrl_min_incremento  = r_min_inc;
    assign bus.ctrl_hora_incremento = r_hora_inc;
    assign bus.ctrl_blank_min       = r_blank_min;
    assign bus.ctrl_blank_hora      = r_blank_hora;
endmodule

// File: tb/tb_ctrl_relogio.sv
// Directed bench for ctrl_relogio with shortened timing (6-cycle minute, 4-cycle blink).
import relogio_pkg::*;

module tb_ctrl_relogio;
    localparam int P_CLK_HZ = 2;
    localparam int P_SPM    = 3;
    localparam int P_BLINK  = 4;
    localparam int P_HOLD   = 4;
    localparam int P_REP    = 2;

    logic ctrl_clock = 1'b0;
    logic ctrl_reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n_min  = 0;
    int   n_hora = 0;
    int   base_min, base_hora;

    ctrl_relogio_if u_if();

    ctrl_relogio #(
        .CLK_HZ(P_CLK_HZ), .SEC_PER_MIN(P_SPM), .BLINK_CYCLES(P_BLINK),
        .HOLD_CYCLES(P_HOLD), .REPEAT_CYCLES(P_REP)
    ) u_dut (
        .ctrl_clock(ctrl_clock),
        .ctrl_reset(ctrl_reset),
        .bus(u_if.slave)
    );

    always #5 ctrl_clock = ~ctrl_clock;

    always @(negedge ctrl_clock) begin
        if (u_if.ctrl_min_incremento)  n_min++;
        if (u_if.ctrl_hora_incremento) n_hora++;
    end

    task automatic verifica(input string tag, input int obs, input int esp);
        checks++;
        if (obs !== esp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
        end
    endtask

    task automatic ciclo();
        @(posedge ctrl_clock);
        #1;
    endtask

    // Press for one sample, release; returns just after the edge where the result shows.
    task automatic aperta(input logic modo, input logic inc);
        u_if.ctrl_btn_modo = modo;
        u_if.ctrl_btn_inc  = inc;
        ciclo();
        u_if.ctrl_btn_modo = 1'b0;
        u_if.ctrl_btn_inc  = 1'b0;
        ciclo();
    endtask

    initial begin
        u_if.ctrl_btn_modo  = 1'b0;
        u_if.ctrl_btn_inc   = 1'b0;
        u_if.ctrl_carry_min = 1'b0;
        ciclo();
        ciclo();
        verifica("rst_modo",      int'(u_if.ctrl_modo), 0);
        verifica("rst_min_en",    int'(u_if.ctrl_min_enable), 1);
        verifica("rst_hora_en",   int'(u_if.ctrl_hora_enable), 1);
        verifica("rst_min_inc",   int'(u_if.ctrl_min_incremento), 0);
        verifica("rst_hora_inc",  int'(u_if.ctrl_hora_incremento), 0);
        verifica("rst_blank_min", int'(u_if.ctrl_blank_min), 0);
        verifica("rst_blank_hr",  int'(u_if.ctrl_blank_hora), 0);
        ctrl_reset = 1'b0;

        // RUN: a pulse every 6 cycles after release
        for (int k = 1; k <= 18; k++) begin
            ciclo();
            verifica($sformatf("tick_%0d", k), int'(u_if.ctrl_min_incremento), (k % 6 == 0) ? 1 : 0);
        end

        // carry one cycle after the tick is forwarded one cycle later
        ciclo();
        verifica("carry_pre", int'(u_if.ctrl_hora_incremento), 0);
        u_if.ctrl_carry_min = 1'b1;
        ciclo();
        u_if.ctrl_carry_min = 1'b0;
        verifica("carry_fwd", int'(u_if.ctrl_hora_incremento), 1);
        ciclo();
        verifica("carry_1cyc", int'(u_if.ctrl_hora_incremento), 0);

        // hour set: three inc presses, no minute pulses
        base_min  = n_min;
        base_hora = n_hora;
        aperta(1'b1, 1'b0);
        verifica("hr_modo",    int'(u_if.ctrl_modo), 1);
        verifica("hr_min_en",  int'(u_if.ctrl_min_enable), 0);
        verifica("hr_hora_en", int'(u_if.ctrl_hora_enable), 1);
        for (int p = 0; p < 3; p++) begin
            aperta(1'b0, 1'b1);
            verifica($sformatf("hr_inc_%0d", p), int'(u_if.ctrl_hora_incremento), 1);
        end
        ciclo();
        verifica("hr_n_hora", n_hora - base_hora, 3);
        verifica("hr_n_min",  n_min - base_min, 0);

        // minute set: set-origin carry never reaches the hour
        aperta(1'b1, 1'b0);
        verifica("mn_modo",    int'(u_if.ctrl_modo), 2);
        verifica("mn_min_en",  int'(u_if.ctrl_min_enable), 1);
        verifica("mn_hora_en", int'(u_if.ctrl_hora_enable), 0);
        aperta(1'b0, 1'b1);
        verifica("mn_inc", int'(u_if.ctrl_min_incremento), 1);
        u_if.ctrl_carry_min = 1'b1;
        u_if.ctrl_btn_modo  = 1'b1;
        ciclo();
        u_if.ctrl_carry_min = 1'b0;
        u_if.ctrl_btn_modo  = 1'b0;
        verifica("mn_carry_blk", int'(u_if.ctrl_hora_incremento), 0);
        ciclo();
        verifica("mn_back_run", int'(u_if.ctrl_modo), 0);
        u_if.ctrl_carry_min = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            ciclo();
            if (k == 1) begin
                u_if.ctrl_carry_min = 1'b0;
                verifica("late_carry_blk", int'(u_if.ctrl_hora_incremento), 0);
            end
            verifica($sformatf("restart_%0d", k), int'(u_if.ctrl_min_incremento), (k == 6) ? 1 : 0);
        end

        // simultaneous mode+inc: mode wins
        aperta(1'b1, 1'b1);
        verifica("sim1_modo", int'(u_if.ctrl_modo), 1);
        verifica("sim1_hora", int'(u_if.ctrl_hora_incremento), 0);
        aperta(1'b1, 1'b1);
        verifica("sim2_modo", int'(u_if.ctrl_modo), 2);
        verifica("sim2_min",  int'(u_if.ctrl_min_incremento), 0);
        aperta(1'b1, 1'b0);
        verifica("sim3_modo",  int'(u_if.ctrl_modo), 0);
        verifica("sim3_bl_mn", int'(u_if.ctrl_blank_min), 0);
        verifica("sim3_bl_hr", int'(u_if.ctrl_blank_hora), 0);
        verifica("sim3_en_mn", int'(u_if.ctrl_min_enable), 1);
        verifica("sim3_en_hr", int'(u_if.ctrl_hora_enable), 1);

        // blink phase then asynchronous reset mid-pulse
        aperta(1'b1, 1'b0);
        ciclo();
        ciclo();
        ciclo();
        verifica("blink_lo", int'(u_if.ctrl_blank_hora), 0);
        ciclo();
        verifica("blink_hi",    int'(u_if.ctrl_blank_hora), 1);
        verifica("blink_mn_lo", int'(u_if.ctrl_blank_min), 0);
        aperta(1'b0, 1'b1);
        verifica("pre_rst_inc",   int'(u_if.ctrl_hora_incremento), 1);
        verifica("pre_rst_blank", int'(u_if.ctrl_blank_hora), 1);
        #2;
        ctrl_reset = 1'b1;
        #1;
        verifica("arst_modo",  int'(u_if.ctrl_modo), 0);
        verifica("arst_inc",   int'(u_if.ctrl_hora_incremento), 0);
        verifica("arst_blank", int'(u_if.ctrl_blank_hora), 0);
        verifica("arst_en_mn", int'(u_if.ctrl_min_enable), 1);
        ciclo();
        ciclo();
        ctrl_reset = 1'b0;
        ciclo();
        verifica("post_rst_inc",  int'(u_if.ctrl_hora_incremento), 0);
        verifica("post_rst_modo", int'(u_if.ctrl_modo), 0);

        // held inc for 10 samples in hour set
        aperta(1'b1, 1'b0);
        verifica("hold_modo", int'(u_if.ctrl_modo), 1);
        u_if.ctrl_btn_inc = 1'b1;
        for (int j = 0; j < 14; j++) begin
            ciclo();
            if (j == 9) u_if.ctrl_btn_inc = 1'b0;
`ifdef CTRL_AUTOREPEAT_EN
            verifica($sformatf("hold_%0d", j), int'(u_if.ctrl_hora_incremento),
                     (j == 1 || j == 5 || j == 7 || j == 9) ? 1 : 0);
`else
            verifica($sformatf("hold_%0d", j), int'(u_if.ctrl_hora_incremento), (j == 1) ? 1 : 0);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
